binary_to_bcd_converter: RTL
============================

Name: binary_to_BCD_converter

Overview:
- Sequential binary-to-packed-BCD converter using iterative double-dabble (shift-and-add-3), one input bit per clock.
- Inverse of the BCD_to_binary_converter block. A 32-bit unsigned value converts to 10 packed BCD digits, so the two blocks form a round-trip pair.
- Sits between datapath arithmetic and display/UART formatting logic. Simple start/done handshake.

Parameters:
- BIN_WIDTH, 32, width of unsigned binary input; also the shift-phase cycle count.
- DIGITS, 10, number of BCD digits output. Requires 10^DIGITS > 2^BIN_WIDTH - 1 (checked by elaboration assertion).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request conversion of binary_i; sampled only when ready_o=1.
- binary_i  input  BIN_WIDTH  unsigned value; captured on the accepting edge only.
- ready_o  output  1  high when idle and able to accept start_i.
- done_o  output  1  one-cycle pulse; BCD_o valid and new.
- BCD_o  output  4*DIGITS  packed BCD result. Digit k occupies bits [4k+3:4k]; digit 0 is the least significant.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, ready_o=1, done_o=0, BCD_o=0.
  - Internal scratch register and counter cleared.
  - Reset mid-conversion aborts the conversion; no done_o pulse follows.
- State machine:
  - IDLE, ready_o=1:
    - On an edge with start_i=1: load shift register {DIGITS*4 zeros, binary_i}, set counter=BIN_WIDTH, go to SHIFT.
    - Otherwise remain in IDLE.
  - SHIFT, ready_o=0:
    - Each edge: every BCD nibble >=5 gets +3, then the combined register shifts left by 1. The binary MSB enters BCD nibble 0 bit 0.
    - Counter decrements on each edge.
    - On the edge that performs the BIN_WIDTH-th shift: BCD_o <= final BCD field, done_o <= 1, state <= IDLE.
  - done_o is registered and cleared on the next edge.
- Latency: start sampled at edge E0; done_o=1 and BCD_o valid in the cycle following edge E(BIN_WIDTH), i.e. E32 for defaults.
- ready_o=1 during the done_o cycle, so back-to-back start is accepted. Throughput is one conversion per BIN_WIDTH+1 cycles.
- start_i is ignored while in SHIFT. No queuing, no effect on the in-flight result.
- binary_i changes after the accepting edge do not affect the result.
- BCD_o holds the last result until the next done_o; it does not expose intermediate values.
- Arithmetic:
  - The add-3 correction is a combinational per-nibble compare (>=5) plus a 4-bit add; it never carries between nibbles.
  - Each nibble is always 0-9 after completion.
  - Unused upper digits are 0.

Optional Feature:
- Macro: BIN2BCD_DIGIT_COUNT_EN.
- Defined:
  - Adds output num_digits_o, width $clog2(DIGITS+1), equal to the index of the highest nonzero digit plus 1.
  - Input 0 yields 1.
  - Updated on the same edge as BCD_o and held with it; reset value 0.
- Not defined:
  - Port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset released, start with binary_i=32'h00001010 (4112) -> done_o pulse exactly 32 edges after the start edge; BCD_o=40'h0000004112. With the macro, num_digits_o=4.
- binary_i=0 -> BCD_o=40'h0000000000 (num_digits_o=1). binary_i=99 -> BCD_o=40'h0000000099.
- binary_i=32'hFFFFFFFF -> BCD_o=40'h4294967295 (num_digits_o=10). binary_i=1_000_000_000 -> BCD_o=40'h1000000000.
- Start 12345, then pulse start_i with 999 and change binary_i during SHIFT -> single done_o; BCD_o=40'h0000012345; ready_o=0 throughout SHIFT.
- Assert rst_ni low at shift cycle 15 of a conversion -> outputs immediately 0/ready_o=1, no done_o. Restart with 7 -> BCD_o=40'h0000000007.
- Back-to-back: start asserted in the done_o cycle with 65535 after 4112 -> second done_o 33 cycles after the first; BCD_o=40'h0000065535.

Source files
------------

// File: rtl/binary_to_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (double-dabble, one input bit per clock).
// Optional digit-count output is enabled by defining BIN2BCD_DIGIT_COUNT_EN.
module binary_to_bcd_converter #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [BIN_WIDTH-1:0]    binary_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [4*DIGITS-1:0]     BCD_o
`ifdef BIN2BCD_DIGIT_COUNT_EN
  ,
  output logic [$clog2(DIGITS+1)-1:0] num_digits_o
`endif
);

  localparam int BCDW = 4 * DIGITS;
  localparam int SW   = BCDW + BIN_WIDTH;
  localparam int CW   = $clog2(BIN_WIDTH + 1);
  // Decimal digits needed for 2^BIN_WIDTH-1, using log10(2) ~= 0.30103.
  localparam int MIN_DIGITS = (BIN_WIDTH * 30103) / 100000 + 1;

  if (DIGITS < MIN_DIGITS) begin : g_digits_too_small
    $error("binary_to_bcd_converter: DIGITS too small for BIN_WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BCDW-1:0] bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [BCDW-1:0] bcd_adj;
  logic [SW-1:0]   shifted;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    bcd_adj = shift_q[SW-1:BIN_WIDTH];
    for (int k = 0; k < DIGITS; k++) begin
      if (shift_q[BIN_WIDTH+4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = shift_q[BIN_WIDTH+4*k +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, shift_q[BIN_WIDTH-1:0]} << 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = {{BCDW{1'b0}}, binary_i};
          cnt_d   = CW'(BIN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[SW-1:BIN_WIDTH];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = done_q;
  assign BCD_o   = bcd_q;

`ifdef BIN2BCD_DIGIT_COUNT_EN
  localparam int NDW = $clog2(DIGITS + 1);
  logic [NDW-1:0] nd_q, nd_calc;

  // Highest nonzero digit index + 1 of the final field; zero reports one digit.
  always_comb begin
    nd_calc = NDW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted[BIN_WIDTH+4*k +: 4] != 4'd0) nd_calc = NDW'(k + 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     nd_q <= '0;
    else if (done_d) nd_q <= nd_calc;
  end

  assign num_digits_o = nd_q;
`endif

endmodule
